// File: rtl/multicycle_control.sv
// Control unit for a five-stage-style multicycle MIPS datapath.
// Moore FSM; only the FETCH write strobes and the illegal-opcode flag look at inputs.
module multicycle_control #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RCOMPL = 4'd7,
        BEQ    = 4'd8,
        JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur;
    state_t nxt;
    logic   ready;

    // With MEM_WAIT=0 the memory is assumed single-cycle and mem_ready is ignored.
    assign ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt        = cur;
        illegal_op = 1'b0;
        case (cur)
            FETCH: begin
                if (ready) nxt = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = REXEC;
                    OP_BEQ:       nxt = BEQ;
                    OP_J:         nxt = JUMP;
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                nxt = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                if (ready) nxt = MEMWB;
            end
            MEMWR: begin
                if (ready) nxt = FETCH;
            end
            MEMWB:   nxt = FETCH;
            REXEC:   nxt = RCOMPL;
            RCOMPL:  nxt = FETCH;
            BEQ:     nxt = FETCH;
            JUMP:    nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        case (cur)
            FETCH: begin
                // IR and PC only latch once the instruction word has arrived.
                MemRead = 1'b1;
                IRWrite = ready;
                PCWrite = ready;
                ALUSrcB = 2'b01;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            RCOMPL: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: the driver pushes the expected
// state/control word for each cycle, a negedge monitor pops and compares.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;
    logic       illegal_op;

    multicycle_control #(.MEM_WAIT(1)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .state(state), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,RegWrite,RegDst,
    //             PCSource,ALUOp,ALUSrcB}
    localparam logic [15:0] C_FETCH_R = 16'b1001010000_00_00_01;
    localparam logic [15:0] C_FETCH_S = 16'b0001000000_00_00_01;
    localparam logic [15:0] C_DECODE  = 16'b0000000000_00_00_11;
    localparam logic [15:0] C_MEMADR  = 16'b0000000100_00_00_10;
    localparam logic [15:0] C_MEMRD   = 16'b0011000000_00_00_00;
    localparam logic [15:0] C_MEMWB   = 16'b0000001010_00_00_00;
    localparam logic [15:0] C_MEMWR   = 16'b0010100000_00_00_00;
    localparam logic [15:0] C_REXEC   = 16'b0000000100_00_10_00;
    localparam logic [15:0] C_RCOMPL  = 16'b0000000011_00_00_00;
    localparam logic [15:0] C_BEQ     = 16'b0100000100_01_01_00;
    localparam logic [15:0] C_JUMP    = 16'b1000000000_10_00_00;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, BAD = 6'b111111;

    logic [20:0] exp_q[$];
    int          step_q[$];
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic rst, input logic [5:0] o, input logic rdy,
                        input logic [3:0] st, input logic [15:0] ctrl, input logic ill);
        @(posedge clk);
        #1;
        reset     = rst;
        op        = o;
        mem_ready = rdy;
        exp_q.push_back({st, ctrl, ill});
        step_q.push_back(step_no);
        step_no++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] exp_w;
            logic [20:0] got_w;
            int          sn;
            exp_w = exp_q.pop_front();
            sn    = step_q.pop_front();
            got_w = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, illegal_op};
            checks++;
            if (got_w !== exp_w) begin
                errors++;
                $display("FAIL step%0d state/ctrl/ill got %b required %b", sn, got_w, exp_w);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        op        = RT;
        mem_ready = 1'b0;

        // reset state: FETCH, stalled fetch has no IR/PC write
        step(1, RT, 0, 4'd0, C_FETCH_S, 0);

        // lw, no stalls: 0,1,2,3,4
        step(0, LW, 1, 4'd0, C_FETCH_R, 0);
        step(0, LW, 1, 4'd1, C_DECODE,  0);
        step(0, LW, 1, 4'd2, C_MEMADR,  0);
        step(0, LW, 1, 4'd3, C_MEMRD,   0);
        step(0, LW, 1, 4'd4, C_MEMWB,   0);

        // sw with 3 stall cycles in MEMWR
        step(0, SW, 1, 4'd0, C_FETCH_R, 0);
        step(0, SW, 1, 4'd1, C_DECODE,  0);
        step(0, SW, 0, 4'd2, C_MEMADR,  0);
        step(0, SW, 0, 4'd5, C_MEMWR,   0);
        step(0, SW, 0, 4'd5, C_MEMWR,   0);
        step(0, SW, 0, 4'd5, C_MEMWR,   0);
        step(0, SW, 1, 4'd5, C_MEMWR,   0);

        // fetch stall, then R-type
        step(0, RT, 0, 4'd0, C_FETCH_S, 0);
        step(0, RT, 1, 4'd0, C_FETCH_R, 0);
        step(0, RT, 1, 4'd1, C_DECODE,  0);
        step(0, RT, 1, 4'd6, C_REXEC,   0);
        step(0, RT, 1, 4'd7, C_RCOMPL,  0);

        // beq then j
        step(0, BQ, 1, 4'd0, C_FETCH_R, 0);
        step(0, BQ, 1, 4'd1, C_DECODE,  0);
        step(0, BQ, 1, 4'd8, C_BEQ,     0);
        step(0, JJ, 1, 4'd0, C_FETCH_R, 0);
        step(0, JJ, 1, 4'd1, C_DECODE,  0);
        step(0, JJ, 1, 4'd9, C_JUMP,    0);

        // illegal opcode: flag only in DECODE, back to FETCH
        step(0, BAD, 1, 4'd0, C_FETCH_R, 0);
        step(0, BAD, 1, 4'd1, C_DECODE,  1);
        step(0, BAD, 0, 4'd0, C_FETCH_S, 0);

        // reset while stalled in MEMRD
        step(0, LW, 1, 4'd0, C_FETCH_R, 0);
        step(0, LW, 1, 4'd1, C_DECODE,  0);
        step(0, LW, 0, 4'd2, C_MEMADR,  0);
        step(0, LW, 0, 4'd3, C_MEMRD,   0);
        step(1, LW, 1, 4'd3, C_MEMRD,   0);
        step(0, LW, 0, 4'd0, C_FETCH_S, 0);
        step(0, LW, 0, 4'd0, C_FETCH_S, 0);
        step(0, LW, 1, 4'd0, C_FETCH_R, 0);
        step(0, LW, 1, 4'd1, C_DECODE,  0);

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, meaning: 1 = memory states stall on mem_ready; 0 = mem_ready is ignored and treated as 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port op, input, 6 bits: opcode field of the held instruction register.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst, each output, 1 bit: datapath controls.
REQ-007 SHALL have ports PCSource, ALUOp and ALUSrcB, each output, 2 bits: datapath mux selects.
REQ-008 SHALL have port state, output, 4 bits: current state encoding, for debug.
REQ-009 SHALL have port illegal_op, output, 1 bit: one-cycle pulse flagging an unsupported opcode.

Function
REQ-010 SHALL be a Moore FSM; all controls decode from the current state only, except the mem_ready-gated strobes in REQ-021.
REQ-011 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RCOMPL=7, BEQ=8, JUMP=9.
REQ-012 SHALL decode opcodes as: R-type=000000, lw=100011, sw=101011, beq=000100, j=000010.
REQ-013 SHALL move FETCH->DECODE when mem_ready=1, and stay in FETCH otherwise.
REQ-014 SHALL leave DECODE as follows: lw/sw->MEMADR; R-type->REXEC; beq->BEQ; j->JUMP; any other opcode->FETCH with illegal_op=1 for exactly that cycle.
REQ-015 SHALL leave MEMADR for MEMRD on lw and for MEMWR on sw.
REQ-016 SHALL move MEMRD->MEMWB, and MEMWR->FETCH, only when mem_ready=1, and hold the state otherwise.
REQ-017 SHALL move MEMWB->FETCH, REXEC->RCOMPL, RCOMPL->FETCH, BEQ->FETCH and JUMP->FETCH unconditionally.
REQ-018 SHALL drive these outputs in FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-019 SHALL drive these outputs in the remaining states:
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: MemRead=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEMWR: IorD=1; MemWrite is gated per REQ-021.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- RCOMPL: RegWrite=1, RegDst=1, MemtoReg=0.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
REQ-020 SHALL drive every output not listed for the current state to 0.
REQ-021 SHALL apply these gates:
- FETCH: IRWrite=PCWrite=mem_ready.
- MEMWR: MemWrite=1 for every cycle in that state, so it is held through any stall.
- MEMRD: MemRead held for every cycle in that state.
- Stalled cycles: no register or PC write.
REQ-022 SHALL, when MEM_WAIT=0, take every memory-state transition in one cycle.
REQ-023 SHALL give these instruction latencies with mem_ready tied high: lw 5 cycles; sw 4; R-type 4; beq 3; j 3; illegal 2.
REQ-024 SHALL ignore op in all states except DECODE, MEMADR and the illegal-opcode check.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, enter FETCH from any state, including a stalled MEMRD or MEMWR; the in-flight instruction is abandoned.
REQ-026 SHALL drive illegal_op=0 in the cycle after reset and hold all state-decoded outputs at their FETCH values.
REQ-027 SHALL let reset override mem_ready and op.

Verification
REQ-028 SHALL cover: reset, then op=100011 with mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4.
REQ-029 SHALL cover: op=101011 with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-030 SHALL cover: op=000000 -> states 0,1,6,7; ALUOp=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-031 SHALL cover: op=000100, then op=000010 -> PCWriteCond=1 with PCSource=01 in state 8; PCWrite=1 with PCSource=10 in state 9.
REQ-032 SHALL cover: op=111111 -> illegal_op pulses once in DECODE, then FETCH, with no write strobes.
REQ-033 SHALL cover: reset asserted while stalled in MEMRD -> state=0 next cycle; IRWrite=0 until mem_ready=1.
